// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the ALU issue controller and its host/ALU environment.
// The master side is the host plus ALU; the slave side is the controller.
interface alu_issue_ctrl_if #(
  parameter int DW  = 8,
  parameter int OPW = 6,
  parameter int RAW = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [OPW+3*RAW-1:0]   in_instr;
  logic                   wr_en;
  logic [RAW-1:0]         wr_sel;
  logic [DW-1:0]          wr_data;
  logic [RAW-1:0]         rd_sel;
  logic [DW-1:0]          rd_data;
  logic [DW-1:0]          alu_a;
  logic [DW-1:0]          alu_b;
  logic [OPW-1:0]         alu_op;
  logic [DW-1:0]          alu_c;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output in_valid, in_instr, wr_en, wr_sel, wr_data, rd_sel, alu_c,
    input  in_ready, rd_data, alu_a, alu_b, alu_op, busy, done, err
  );

  modport slave (
    input  in_valid, in_instr, wr_en, wr_sel, wr_data, rd_sel, alu_c,
    output in_ready, rd_data, alu_a, alu_b, alu_op, busy, done, err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit clocked ALU: holds a small register
// file, issues one instruction at a time with registered operands and opcode,
// waits out the ALU's one-clock latency and writes the result back.
module alu_issue_ctrl #(
  parameter int DW   = 8,
  parameter int OPW  = 6,
  parameter int NREG = 4,
  parameter int RAW  = 2
) (
  input logic       clk,
  input logic       rst,
  alu_issue_ctrl_if.slave bus
);

  localparam int IW = OPW + 3 * RAW;

  localparam logic [OPW-1:0] OP_ADD     = 6'b101001;
  localparam logic [OPW-1:0] OP_SUB     = 6'b000110;
  localparam logic [OPW-1:0] OP_ZERO    = 6'b000011;
  localparam logic [OPW-1:0] OP_AND     = 6'b011011;
  localparam logic [OPW-1:0] OP_OR      = 6'b011110;
  localparam logic [OPW-1:0] OP_ADD1    = 6'b000001;
  localparam logic [OPW-1:0] OP_SUB1    = 6'b011111;
  localparam logic [OPW-1:0] OP_ADDSUB1 = 6'b010011;
  localparam logic [OPW-1:0] OP_XOR     = 6'b101100;
  localparam logic [OPW-1:0] OP_ADT     = 6'b111110;
  localparam logic [OPW-1:0] OP_BDT     = 6'b110100;
  localparam logic [OPW-1:0] OP_NOTA    = 6'b100000;
  localparam logic [OPW-1:0] OP_NOTB    = 6'b101010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t         state;
  state_t         stateNext;
  logic [DW-1:0]  rf [NREG];
  logic [RAW-1:0] rdQ;

  logic [OPW-1:0] opcode;
  logic [RAW-1:0] rdField;
  logic [RAW-1:0] rsField;
  logic [RAW-1:0] rtField;
  logic           opSupported;
  logic           issueEn;
  logic           hostWrEn;
  logic           inReady;
  logic           busyInt;
  logic           doneInt;
  logic           errInt;

  assign opcode  = bus.in_instr[IW-1 -: OPW];
  assign rdField = bus.in_instr[3*RAW-1 -: RAW];
  assign rsField = bus.in_instr[2*RAW-1 -: RAW];
  assign rtField = bus.in_instr[RAW-1:0];

  // Only opcodes the ALU actually implements may ever reach alu_op.
  always_comb begin
    opSupported = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_ZERO, OP_AND, OP_OR, OP_ADD1, OP_SUB1,
      OP_ADDSUB1, OP_XOR, OP_ADT, OP_BDT, OP_NOTA, OP_NOTB: opSupported = 1'b1;
      default: opSupported = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and handshake/status decode; a request is taken only in IDLE.
  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    busyInt   = 1'b1;
    doneInt   = 1'b0;
    errInt    = 1'b0;
    issueEn   = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        busyInt = 1'b0;
        if (bus.in_valid) begin
          if (opSupported) begin
            issueEn   = 1'b1;
            stateNext = ISSUE;
          end else begin
            stateNext = ERR;
          end
        end
      end
      ISSUE: stateNext = WB;
      WB: begin
        doneInt   = 1'b1;
        stateNext = IDLE;
      end
      ERR: begin
        errInt    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign hostWrEn = (state == IDLE) && bus.wr_en;

  // Operand/opcode registers load on an accepted supported instruction and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= OP_ZERO;
      rdQ        <= '0;
    end else if (issueEn) begin
      bus.alu_a  <= rf[rsField];
      bus.alu_b  <= rf[rtField];
      bus.alu_op <= opcode;
      rdQ        <= rdField;
    end
  end

  // Register file: ALU writeback in WB, host writes only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (state == WB) begin
      rf[rdQ] <= bus.alu_c;
    end else if (hostWrEn) begin
      rf[bus.wr_sel] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = rf[bus.rd_sel];
  assign bus.in_ready = inReady;
  assign bus.busy     = busyInt;
  assign bus.done     = doneInt;
  assign bus.err      = errInt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural clocked ALU.
// Stimulus pushes expected writebacks/rejections into a scoreboard queue; a
// monitor pops them whenever the controller pulses done or err.
module tb_alu_issue_ctrl;

  typedef struct {
    logic       isErr;
    logic [1:0] rd;
    logic [7:0] val;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] old;
    logic [5:0] op;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_issue_ctrl_if #(.DW(8), .OPW(6), .RAW(2)) bus ();

  alu_issue_ctrl #(.DW(8), .OPW(6), .NREG(4), .RAW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  item_t      sbQ[$];
  item_t      mItem;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] mdl [4];
  logic [5:0] lastOp;
  logic       stimOwns = 1'b0;
  logic [1:0] stimSel = 2'd0;
  logic [1:0] monSel = 2'd0;
  logic       chkPending = 1'b0;
  logic [7:0] chkVal;

  assign bus.rd_sel = stimOwns ? stimSel : monSel;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic logic isSupported(input logic [5:0] op);
    case (op)
      6'b101001, 6'b000110, 6'b000011, 6'b011011, 6'b011110, 6'b000001, 6'b011111,
      6'b010011, 6'b101100, 6'b111110, 6'b110100, 6'b100000, 6'b101010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] aluFn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      6'b101001: return a + b;
      6'b000110: return a - b;
      6'b000011: return 8'h00;
      6'b011011: return a & b;
      6'b011110: return a | b;
      6'b000001: return a + 8'h01;
      6'b011111: return a - 8'h01;
      6'b010011: return a + b - 8'h01;
      6'b101100: return a ^ b;
      6'b111110: return a;
      6'b110100: return b;
      6'b100000: return ~a;
      6'b101010: return ~b;
      default:   return 8'h00;
    endcase
  endfunction

  // Behavioural ALU: one-clock registered result, holds c on unknown opcodes.
  initial bus.alu_c = 8'h00;
  always @(posedge clk) begin
    if (isSupported(bus.alu_op)) bus.alu_c <= aluFn(bus.alu_op, bus.alu_a, bus.alu_b);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: consumes one scoreboard entry per done/err pulse.
  always @(negedge clk) begin
    if (chkPending) begin
      checkOutput("rd_new", {24'd0, bus.rd_data}, {24'd0, chkVal});
      chkPending = 1'b0;
    end
    if (bus.done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexp_done", 32'd1, 32'd0);
      end else begin
        mItem = sbQ.pop_front();
        checkOutput("done_kind", {31'd0, mItem.isErr}, 32'd0);
        checkOutput("wb_alu_a", {24'd0, bus.alu_a}, {24'd0, mItem.a});
        checkOutput("wb_alu_b", {24'd0, bus.alu_b}, {24'd0, mItem.b});
        checkOutput("wb_alu_op", {26'd0, bus.alu_op}, {26'd0, mItem.op});
        monSel = mItem.rd;
        #1;
        checkOutput("rd_old", {24'd0, bus.rd_data}, {24'd0, mItem.old});
        chkVal     = mItem.val;
        chkPending = 1'b1;
      end
    end
    if (bus.err) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexp_err", 32'd1, 32'd0);
      end else begin
        mItem = sbQ.pop_front();
        checkOutput("err_kind", {31'd0, mItem.isErr}, 32'd1);
        checkOutput("err_alu_op", {26'd0, bus.alu_op}, {26'd0, mItem.op});
        checkOutput("err_no_done", {31'd0, bus.done}, 32'd0);
      end
    end
  end

  // Host register write; starts and ends one time unit after a rising edge.
  task automatic hostWrite(input logic [1:0] sel, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_data = data;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    mdl[sel]  = data;
  endtask

  // Reads the whole register file through rd_sel against the bench model.
  task automatic readBack(input string tag);
    @(posedge clk); #1;
    stimOwns = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stimSel = i[1:0];
      #1;
      checkOutput($sformatf("%s_r%0d", tag, i), {24'd0, bus.rd_data}, {24'd0, mdl[i]});
    end
    stimOwns = 1'b0;
    @(posedge clk); #1;
  endtask

  // Presents one instruction; expVal is the hand-computed writeback value.
  task automatic applyStimulus(input logic [5:0] op, input logic [1:0] rd, input logic [1:0] rs,
                               input logic [1:0] rt, input logic [7:0] expVal, input logic holdValid);
    item_t it;
    logic  sup;
    sup          = isSupported(op);
    bus.in_instr = {op, rd, rs, rt};
    bus.in_valid = 1'b1;
    it.isErr = !sup;
    it.rd    = rd;
    it.val   = expVal;
    it.a     = mdl[rs];
    it.b     = mdl[rt];
    it.old   = mdl[rd];
    it.op    = sup ? op : lastOp;
    sbQ.push_back(it);
    @(posedge clk); #1;
    if (!holdValid) bus.in_valid = 1'b0;
    bus.wr_en = 1'b0;
    if (sup) begin
      checkOutput("iss_alu_a", {24'd0, bus.alu_a}, {24'd0, it.a});
      checkOutput("iss_alu_b", {24'd0, bus.alu_b}, {24'd0, it.b});
      checkOutput("iss_alu_op", {26'd0, bus.alu_op}, {26'd0, op});
      checkOutput("iss_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("iss_busy", {31'd0, bus.busy}, 32'd1);
      if (holdValid) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 2'd0;
        bus.wr_data = 8'hAA;
      end
      @(posedge clk); #1;
      checkOutput("wb_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.wr_en    = 1'b0;
      checkOutput("idle_ready", {31'd0, bus.in_ready}, 32'd1);
      mdl[rd] = expVal;
      lastOp  = op;
    end else begin
      checkOutput("err_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      checkOutput("err_back_ready", {31'd0, bus.in_ready}, 32'd1);
    end
  endtask

  // Bounded run time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.wr_en    = 1'b0;
    bus.wr_sel   = '0;
    bus.wr_data  = '0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    lastOp = 6'b000011;

    @(posedge clk); #1;
    checkOutput("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_alu_op", {26'd0, bus.alu_op}, 32'd3);
    checkOutput("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
    checkOutput("rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_err", {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    readBack("rst");

    hostWrite(2'd0, 8'h05);
    hostWrite(2'd1, 8'h03);
    applyStimulus(6'b101001, 2'd2, 2'd0, 2'd1, 8'h08, 1'b0);  // Add 05+03
    applyStimulus(6'b000110, 2'd3, 2'd1, 2'd0, 8'hFE, 1'b0);  // Sub 03-05
    hostWrite(2'd0, 8'hFF);
    hostWrite(2'd1, 8'h01);
    applyStimulus(6'b010011, 2'd2, 2'd0, 2'd1, 8'hFF, 1'b0);  // Addsub1 FF+01-1
    applyStimulus(6'b101100, 2'd3, 2'd0, 2'd2, 8'h00, 1'b0);  // Xor FF^FF
    applyStimulus(6'b101001, 2'd0, 2'd0, 2'd1, 8'h00, 1'b0);  // Add FF+01 wraps
    applyStimulus(6'b011111, 2'd1, 2'd0, 2'd0, 8'hFF, 1'b0);  // Sub1 00-1 wraps
    readBack("ops");

    applyStimulus(6'b111111, 2'd2, 2'd1, 2'd1, 8'h00, 1'b0);  // rejected opcode
    readBack("err");
    applyStimulus(6'b000011, 2'd2, 2'd1, 2'd1, 8'h00, 1'b0);  // Zero

    applyStimulus(6'b101001, 2'd2, 2'd1, 2'd1, 8'hFE, 1'b1);  // held valid, FF+FF
    readBack("hold");

    bus.in_instr = {6'b101001, 2'd0, 2'd1, 2'd2};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("abort_iss_a", {24'd0, bus.alu_a}, 32'hFF);
    @(posedge clk); #1;
    checkOutput("abort_wb_done", {31'd0, bus.done}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_done", {31'd0, bus.done}, 32'd0);
    checkOutput("abort_alu_op", {26'd0, bus.alu_op}, 32'd3);
    checkOutput("abort_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    lastOp = 6'b000011;
    readBack("abort");

    hostWrite(2'd0, 8'h05);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 2'd0;
    bus.wr_data = 8'h77;
    applyStimulus(6'b111110, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0);  // Adt with same-edge write
    mdl[0] = 8'h77;
    readBack("same");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", sbQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
